// File: rtl/uart_arbiter.sv
// uart_arbiter
//   Arbitrates two requesters (m0, m1) onto one downstream UART register bus.
//   One transfer is in flight at a time. The FSM walks IDLE -> BUSY -> RELEASE -> IDLE.
//   The grant is round-robin, or fixed priority with m0 winning, as FIXED_PRIORITY selects.
//   A transfer with no downstream i_ready within TIMEOUT BUSY cycles is aborted.
//   TIMEOUT = 0 disables the abort.
//
// Ports
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_mX_request/rw/address/wdata    requester X command (held until o_mX_ready)
//   o_mX_rdata                       registered read data for requester X
//   o_mX_ready                       one-cycle completion pulse for requester X
//   o_request/o_rw/o_address/o_wdata downstream command, stable for the whole transfer
//   i_rdata, i_ready                 downstream response
//   o_timeout                        one-cycle pulse when a transfer is aborted
//   o_busy                           high whenever the FSM is outside IDLE
module uart_arbiter #(
    parameter int TIMEOUT        = 1023,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [1:0]  i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ready,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [1:0]  i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ready,
    output logic        o_request,
    output logic        o_rw,
    output logic [1:0]  o_address,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_ready,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q;
    logic          grant_q;   // 0 = m0, 1 = m1
    logic          last_q;    // requester served most recently
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          rw_q;
    logic [1:0]    addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;
    logic          ready0_q;
    logic          ready1_q;
    logic          timeout_q;
    logic          busy_q;

    logic          grant_d;
    logic [CW-1:0] cnt_d;
    logic          to_hit;
    logic          served_req;

    // Arbitration. A tie in round-robin mode goes to whoever was not served last.
    always_comb begin
        grant_d = 1'b0;
        if (FIXED_PRIORITY != 0) begin
            grant_d = !i_m0_request;
        end else if (i_m0_request && i_m1_request) begin
            grant_d = !last_q;
        end else begin
            grant_d = !i_m0_request;
        end
    end

    // cnt_q is 0 in the first BUSY cycle, so cnt_d is the number of BUSY cycles
    // spent so far, including the current one. o_request is therefore held for
    // exactly TIMEOUT cycles before an abort.
    assign cnt_d      = cnt_q + CW'(1);
    assign to_hit     = (TIMEOUT != 0) && (cnt_d == TO_LIMIT);
    assign served_req = grant_q ? i_m1_request : i_m0_request;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= 32'd0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_m0_request || i_m1_request) begin
                        grant_q <= grant_d;
                        req_q   <= 1'b1;
                        rw_q    <= grant_d ? i_m1_rw      : i_m0_rw;
                        addr_q  <= grant_d ? i_m1_address : i_m0_address;
                        wdata_q <= grant_d ? i_m1_wdata   : i_m0_wdata;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready arriving in the same cycle as the timeout wins.
                    if (i_ready || to_hit) begin
                        req_q     <= 1'b0;
                        timeout_q <= !i_ready;
                        // An aborted transfer still counts as served for fairness.
                        last_q    <= grant_q;
                        state_q   <= RELEASE;
                        if (grant_q) begin
                            rdata1_q <= i_ready ? i_rdata : 32'hFFFF_FFFF;
                            ready1_q <= 1'b1;
                        end else begin
                            rdata0_q <= i_ready ? i_rdata : 32'hFFFF_FFFF;
                            ready0_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE: begin
                    if (!served_req) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_request  = req_q;
    assign o_rw       = rw_q;
    assign o_address  = addr_q;
    assign o_wdata    = wdata_q;
    assign o_m0_rdata = rdata0_q;
    assign o_m1_rdata = rdata1_q;
    assign o_m0_ready = ready0_q;
    assign o_m1_ready = ready1_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter.
// dut_a is round-robin with TIMEOUT=8. dut_b is fixed priority with the timeout disabled.
// sel routes the shared stimulus to one instance and observes that instance's outputs.
module tb_uart_arbiter;

    localparam int TO_A = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [1:0]  m_req;
    logic [1:0]  m_rw;
    logic [1:0]  m_addr [2];
    logic [31:0] m_wd   [2];
    logic        ds_ready;
    logic [31:0] ds_rdata;

    always #5 clk = ~clk;

    logic a_m0_req, a_m1_req, a_ds_ready, b_m0_req, b_m1_req, b_ds_ready;
    assign a_m0_req   = m_req[0] & ~sel;
    assign a_m1_req   = m_req[1] & ~sel;
    assign a_ds_ready = ds_ready & ~sel;
    assign b_m0_req   = m_req[0] & sel;
    assign b_m1_req   = m_req[1] & sel;
    assign b_ds_ready = ds_ready & sel;

    logic        a_req, a_rw, a_rdy0, a_rdy1, a_to, a_busy;
    logic [1:0]  a_addr;
    logic [31:0] a_wd, a_rd0, a_rd1;
    logic        b_req, b_rw, b_rdy0, b_rdy1, b_to, b_busy;
    logic [1:0]  b_addr;
    logic [31:0] b_wd, b_rd0, b_rd1;

    uart_arbiter #(.TIMEOUT(TO_A), .FIXED_PRIORITY(0)) dut_a (
        .i_clock(clk), .i_reset(rst),
        .i_m0_request(a_m0_req), .i_m0_rw(m_rw[0]), .i_m0_address(m_addr[0]), .i_m0_wdata(m_wd[0]),
        .o_m0_rdata(a_rd0), .o_m0_ready(a_rdy0),
        .i_m1_request(a_m1_req), .i_m1_rw(m_rw[1]), .i_m1_address(m_addr[1]), .i_m1_wdata(m_wd[1]),
        .o_m1_rdata(a_rd1), .o_m1_ready(a_rdy1),
        .o_request(a_req), .o_rw(a_rw), .o_address(a_addr), .o_wdata(a_wd),
        .i_rdata(ds_rdata), .i_ready(a_ds_ready), .o_timeout(a_to), .o_busy(a_busy)
    );

    uart_arbiter #(.TIMEOUT(0), .FIXED_PRIORITY(1)) dut_b (
        .i_clock(clk), .i_reset(rst),
        .i_m0_request(b_m0_req), .i_m0_rw(m_rw[0]), .i_m0_address(m_addr[0]), .i_m0_wdata(m_wd[0]),
        .o_m0_rdata(b_rd0), .o_m0_ready(b_rdy0),
        .i_m1_request(b_m1_req), .i_m1_rw(m_rw[1]), .i_m1_address(m_addr[1]), .i_m1_wdata(m_wd[1]),
        .o_m1_rdata(b_rd1), .o_m1_ready(b_rdy1),
        .o_request(b_req), .o_rw(b_rw), .o_address(b_addr), .o_wdata(b_wd),
        .i_rdata(ds_rdata), .i_ready(b_ds_ready), .o_timeout(b_to), .o_busy(b_busy)
    );

    logic        v_req, v_rw, v_rdy0, v_rdy1, v_to, v_busy;
    logic [1:0]  v_addr;
    logic [31:0] v_wd, v_rd0, v_rd1;
    assign v_req  = sel ? b_req  : a_req;
    assign v_rw   = sel ? b_rw   : a_rw;
    assign v_rdy0 = sel ? b_rdy0 : a_rdy0;
    assign v_rdy1 = sel ? b_rdy1 : a_rdy1;
    assign v_to   = sel ? b_to   : a_to;
    assign v_busy = sel ? b_busy : a_busy;
    assign v_addr = sel ? b_addr : a_addr;
    assign v_wd   = sel ? b_wd   : a_wd;
    assign v_rd0  = sel ? b_rd0  : a_rd0;
    assign v_rd1  = sel ? b_rd1  : a_rd1;

    typedef struct {
        bit          m;
        logic [31:0] rd;
        bit          to;
    } exp_t;

    typedef struct {
        bit          r0;
        bit          r1;
        bit          rw0;
        logic [1:0]  a0;
        logic [31:0] w0;
        bit          rw1;
        logic [1:0]  a1;
        logic [31:0] w1;
        int          lat;    // BUSY cycles before i_ready; -1 = never
        logic [31:0] rd0;
        logic [31:0] rd1;
        bit          first;  // expected first winner
        int          hold;   // extra cycles the first winner keeps requesting
    } vec_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] exp_rd [2];
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl [11];

    task automatic check1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %b, required %b", name, act, req);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each ready/timeout pulse is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (v_rdy0 === 1'b1 || v_rdy1 === 1'b1 || v_to === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: actual m0_ready=%b m1_ready=%b timeout=%b, required no pulse",
                         v_rdy0, v_rdy1, v_to);
            end else begin
                mon_e = q.pop_front();
                check1("mon_m0_ready", v_rdy0, mon_e.m == 1'b0);
                check1("mon_m1_ready", v_rdy1, mon_e.m == 1'b1);
                check32("mon_rdata", mon_e.m ? v_rd1 : v_rd0, mon_e.rd);
                check1("mon_timeout", v_to, mon_e.to);
                exp_rd[mon_e.m] = mon_e.rd;
            end
        end
    end

    // Waits for the grant of requester m and plays the downstream side of the transfer.
    // The transfer completes after lat cycles or, with lat < 0, runs to the timeout.
    // Returns at the first RELEASE sample with the served request dropped.
    task automatic serve(input bit m, input int lat, input logic [31:0] rd,
                         input int wait_exp, input int hold);
        int          t;
        int          busy_n;
        logic        sv_rw;
        logic [1:0]  sv_addr;
        logic [31:0] sv_wd;
        exp_t        e;
        t = 0;
        do begin
            tick();
            t++;
        end while (v_req !== 1'b1 && t < 20);
        check32("grant_wait", 32'(t), 32'(wait_exp));
        if (v_req !== 1'b1) return;
        check1("grant_busy", v_busy, 1'b1);
        check1("grant_rw", v_rw, m_rw[m]);
        check32("grant_address", 32'(v_addr), 32'(m_addr[m]));
        check32("grant_wdata", v_wd, m_wd[m]);
        sv_rw   = m_rw[m];
        sv_addr = m_addr[m];
        sv_wd   = m_wd[m];
        e.m  = m;
        e.rd = (lat < 0) ? 32'hFFFF_FFFF : rd;
        e.to = (lat < 0);
        q.push_back(e);
        busy_n = (lat < 0) ? TO_A : lat + 1;
        for (int c = 1; c <= busy_n; c++) begin
            if (c > 1) begin
                check1("busy_request", v_req, 1'b1);
                check1("busy_rw", v_rw, sv_rw);
                check32("busy_address", 32'(v_addr), 32'(sv_addr));
                check32("busy_wdata", v_wd, sv_wd);
            end
            ds_ready = (c == lat + 1);
            ds_rdata = (c == lat + 1) ? rd : $urandom;
            m_rw[m]   = ~sv_rw;
            m_addr[m] = ~sv_addr;
            m_wd[m]   = $urandom;
            tick();
        end
        ds_ready = 1'b0;
        check1("done_request", v_req, 1'b0);
        check1("done_busy", v_busy, 1'b1);
        check1("done_m0_ready", v_rdy0, m == 1'b0);
        check1("done_m1_ready", v_rdy1, m == 1'b1);
        check1("done_timeout", v_to, lat < 0);
        check32("other_rdata", m ? v_rd0 : v_rd1, exp_rd[!m]);
        for (int h = 0; h < hold; h++) begin
            tick();
            check1("release_busy", v_busy, 1'b1);
            check1("release_request", v_req, 1'b0);
        end
        m_req[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           r0 r1 rw0 a0    w0             rw1 a1    w1             lat rd0            rd1            fst hold
        tbl[0]  = '{1, 0, 0, 2'd2, 32'h0000_0000, 0, 2'd0, 32'h0000_0000,  3, 32'h0000_0041, 32'h0000_0000, 0, 0};
        tbl[1]  = '{0, 1, 0, 2'd0, 32'h0000_0000, 1, 2'd0, 32'h0000_005A,  2, 32'h0000_0000, 32'h0000_1234, 1, 0};
        tbl[2]  = '{1, 1, 0, 2'd1, 32'h1111_0000, 0, 2'd3, 32'h2222_0000,  0, 32'hA5A5_0001, 32'h5A5A_0002, 0, 2};
        tbl[3]  = '{1, 1, 1, 2'd3, 32'hDEAD_BEEF, 1, 2'd1, 32'hCAFE_F00D,  1, 32'h0000_0003, 32'h0000_0004, 0, 0};
        tbl[4]  = '{1, 0, 1, 2'd0, 32'h0000_00FF, 0, 2'd0, 32'h0000_0000,  5, 32'h1357_9BDF, 32'h0000_0000, 0, 0};
        tbl[5]  = '{1, 1, 0, 2'd2, 32'h0000_0000, 1, 2'd3, 32'h8000_0001,  2, 32'h0BAD_0000, 32'h600D_0000, 1, 0};
        tbl[6]  = '{1, 0, 0, 2'd1, 32'h0000_0000, 0, 2'd0, 32'h0000_0000,  7, 32'h7777_0007, 32'h0000_0000, 0, 0};
        tbl[7]  = '{0, 1, 0, 2'd0, 32'h0000_0000, 0, 2'd2, 32'h0000_0000, -1, 32'h0000_0000, 32'h0000_0000, 1, 0};
        tbl[8]  = '{1, 0, 1, 2'd3, 32'h1234_5678, 0, 2'd0, 32'h0000_0000, -1, 32'h0000_0000, 32'h0000_0000, 0, 0};
        tbl[9]  = '{0, 1, 0, 2'd0, 32'h0000_0000, 1, 2'd1, 32'hFFFF_0000,  4, 32'h0000_0000, 32'h0000_0099, 1, 0};
        tbl[10] = '{1, 1, 0, 2'd0, 32'h0000_0000, 0, 2'd0, 32'h0000_0000,  0, 32'h0000_0001, 32'h0000_0002, 0, 1};

        rst = 1'b1;  sel = 1'b0;  m_req = 2'b00;  m_rw = 2'b00;
        m_addr[0] = 2'd0;  m_addr[1] = 2'd0;  m_wd[0] = 32'd0;  m_wd[1] = 32'd0;
        ds_ready = 1'b0;  ds_rdata = 32'd0;
        exp_rd[0] = 32'd0;  exp_rd[1] = 32'd0;
        tick();
        tick();
        check1("reset_request", v_req, 1'b0);
        check1("reset_busy", v_busy, 1'b0);
        check1("reset_m0_ready", v_rdy0, 1'b0);
        check1("reset_m1_ready", v_rdy1, 1'b0);
        check1("reset_timeout", v_to, 1'b0);
        check1("reset_rw", v_rw, 1'b0);
        check32("reset_address", 32'(v_addr), 32'd0);
        check32("reset_wdata", v_wd, 32'd0);
        check32("reset_m0_rdata", v_rd0, 32'd0);
        check32("reset_m1_rdata", v_rd1, 32'd0);
        check1("reset_b_busy", b_busy, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            m_rw      = {tbl[i].rw1, tbl[i].rw0};
            m_addr[0] = tbl[i].a0;
            m_addr[1] = tbl[i].a1;
            m_wd[0]   = tbl[i].w0;
            m_wd[1]   = tbl[i].w1;
            m_req     = {tbl[i].r1, tbl[i].r0};
            if (tbl[i].r0 && tbl[i].r1) begin
                serve(tbl[i].first, tbl[i].lat, tbl[i].first ? tbl[i].rd1 : tbl[i].rd0, 1, tbl[i].hold);
                serve(!tbl[i].first, tbl[i].lat, tbl[i].first ? tbl[i].rd0 : tbl[i].rd1, 2, 0);
            end else begin
                serve(tbl[i].first, tbl[i].lat, tbl[i].first ? tbl[i].rd1 : tbl[i].rd0, 1, tbl[i].hold);
            end
            tick();
        end

        // Reset two cycles into BUSY: everything clears and no ready pulse follows.
        m_rw[0] = 1'b1;  m_addr[0] = 2'd3;  m_wd[0] = 32'hABCD_0000;  m_req = 2'b01;
        tick();
        check1("rb_grant", v_req, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check1("rb_request", v_req, 1'b0);
        check1("rb_busy", v_busy, 1'b0);
        check1("rb_rw", v_rw, 1'b0);
        check32("rb_address", 32'(v_addr), 32'd0);
        check32("rb_wdata", v_wd, 32'd0);
        check32("rb_m0_rdata", v_rd0, 32'd0);
        check32("rb_m1_rdata", v_rd1, 32'd0);
        check1("rb_m0_ready", v_rdy0, 1'b0);
        check1("rb_timeout", v_to, 1'b0);
        rst = 1'b0;
        m_req = 2'b00;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        tick();
        check1("rb_idle_ready", v_rdy0, 1'b0);
        m_rw = 2'b10;  m_addr[0] = 2'd1;  m_addr[1] = 2'd2;
        m_wd[0] = 32'h0000_0011;  m_wd[1] = 32'h0000_0022;  m_req = 2'b11;
        serve(1'b0, 2, 32'h0000_00C0, 1, 0);
        serve(1'b1, 1, 32'h0000_00C1, 2, 0);
        tick();

        // Fixed priority: m0 re-requests in every IDLE cycle and beats a waiting m1.
        tick();
        sel = 1'b1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        m_rw = 2'b00;  m_addr[0] = 2'd1;  m_addr[1] = 2'd2;
        m_wd[0] = 32'h0000_0010;  m_wd[1] = 32'h0000_0020;  m_req = 2'b11;
        for (int r = 0; r < 3; r++) begin
            serve(1'b0, r + 1, 32'h0000_0100 + 32'(r), 1, 0);
            tick();
            if (r < 2) begin
                m_rw[0]   = 1'b0;
                m_addr[0] = 2'd1;
                m_wd[0]   = 32'h0000_0030 + 32'(r);
                m_req[0]  = 1'b1;
            end
        end
        // TIMEOUT=0: a long wait must not abort.
        serve(1'b1, 20, 32'h0000_0BBB, 1, 0);
        tick();
        tick();
        check32("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the number of cycles to wait for downstream ready before aborting; 0 disables the timeout.
REQ-002 SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 selects round-robin and 1 makes m0 always win.
REQ-003 SHALL have port i_clock, input, 1 bit: the single clock.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports i_m0_request / i_m1_request, input, 1 bit each: requester holds high until it sees its ready.
REQ-006 SHALL have ports i_m0_rw / i_m1_rw, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports i_m0_address / i_m1_address, input, 2 bits each: UART register address.
REQ-008 SHALL have ports i_m0_wdata / i_m1_wdata, input, 32 bits each: write data.
REQ-009 SHALL have ports o_m0_rdata / o_m1_rdata, output, 32 bits each: registered read data.
REQ-010 SHALL have ports o_m0_ready / o_m1_ready, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have ports o_request, o_rw, o_address[1:0], o_wdata[31:0], output: the downstream UART bus.
REQ-012 SHALL have ports i_rdata[31:0] and i_ready, input: the downstream UART response.
REQ-013 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a transfer is aborted.
REQ-014 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement the states IDLE, BUSY and RELEASE.
REQ-016 In IDLE, when any request is high, SHALL register the grant, the granted rw/address/wdata and o_request=1, and enter BUSY at the next edge; downstream sees the request 1 cycle after requester assertion.
REQ-017 With FIXED_PRIORITY=0 and both requests high in IDLE, SHALL grant the requester not served last; the last-served pointer resets to m1, so m0 wins the first tie.
REQ-018 With FIXED_PRIORITY=1, SHALL grant m0 whenever i_m0_request is high in IDLE.
REQ-019 In BUSY, SHALL hold o_request, o_rw, o_address and o_wdata stable and ignore changes on any requester's inputs.
REQ-020 In BUSY, when i_ready=1, SHALL at the next edge:
- drop o_request;
- latch i_rdata into the granted o_mX_rdata;
- pulse the granted o_mX_ready for exactly 1 cycle;
- update the last-served pointer;
- enter RELEASE.
REQ-021 SHALL keep the non-granted o_mX_ready at 0 and leave its o_mX_rdata unchanged.
REQ-022 In BUSY, SHALL count cycles with a width of ceil(log2(TIMEOUT+1)) bits, cleared on entering BUSY.
REQ-023 When TIMEOUT!=0 and the count reaches TIMEOUT with i_ready=0, SHALL at the next edge:
- drop o_request;
- load o_mX_rdata with 32'hFFFF_FFFF;
- pulse o_mX_ready and o_timeout for 1 cycle;
- enter RELEASE.
REQ-024 If i_ready=1 in the same cycle the count reaches TIMEOUT, SHALL treat it as a normal completion, with no o_timeout.
REQ-025 In RELEASE, SHALL stay until the served requester's i_mX_request=0, then enter IDLE; the other requester is not granted while in RELEASE.
REQ-026 SHALL add no bubble beyond RELEASE: a pending request in IDLE is granted in that same IDLE cycle.
REQ-027 SHALL NOT let a write versus read transfer change any timing.

Reset
REQ-028 On i_reset=1 at an edge, SHALL set the state to IDLE, the last-served pointer to m1 and the counter to 0.
REQ-029 On reset, SHALL set o_request, o_rw, o_address, o_wdata, o_m0_rdata, o_m1_rdata, o_m0_ready, o_m1_ready, o_timeout and o_busy to 0.
REQ-030 SHALL apply reset in any state, including mid-BUSY; the aborted transfer produces no ready pulse.

Verification
REQ-031 m0 read address 2, downstream i_ready after 3 cycles with i_rdata=32'h0000_0041 -> o_m0_ready is a single pulse, o_m0_rdata=32'h41, o_m1_ready stays 0.
REQ-032 m0 and m1 request simultaneously from reset, each held until ready -> m0 served first, then m1; repeat both -> order m0, m1 again, with no starvation.
REQ-033 FIXED_PRIORITY=1, m0 re-requests continuously while m1 requests -> m0 wins every IDLE arbitration.
REQ-034 TIMEOUT=8, i_ready never asserted -> o_request drops after 8 BUSY cycles, o_mX_rdata=32'hFFFF_FFFF, o_timeout and o_mX_ready pulse together.
REQ-035 m1 write of wdata=32'h5A to address 0 -> o_rw=1, o_address=0, o_wdata=32'h5A held constant from grant until i_ready.
REQ-036 i_reset asserted 2 cycles into BUSY -> all outputs 0 the next cycle, no ready pulse; a fresh request afterwards is served normally.
